// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store sequencer between the pipeline MEM stage and a
// 64-bit word-addressed data memory (combinational read, posedge write).
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN
//   defined   : misaligned half/word/double accesses complete with resp_error
//   undefined : the low address bits are cleared to the natural alignment and
//               the access proceeds normally
//
// Ports
//   clk, reset                        clock, synchronous active-high reset
//   req_valid/write/size/unsigned     request handshake and access type
//   req_addr, req_wdata               byte address, LSB-aligned store data
//   req_ready, stall                  accept indication, pipeline stall
//   resp_valid/rdata/error            one-cycle completion pulse and result
//   mem_read/write/addr/wdata/rdata   data memory interface

// One byte lane of the read-modify-write merge.
module dmem_byte_lane (
  input  logic       sel,
  input  logic [7:0] old_b,
  input  logic [7:0] new_b,
  output logic [7:0] out_b
);
  assign out_b = sel ? new_b : old_b;
endmodule

module dmem_access_ctrl #(
  parameter int MEM_WORDS = 1024,
  parameter int XLEN      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  input  logic            req_write,
  input  logic [1:0]      req_size,
  input  logic            req_unsigned,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            req_ready,
  output logic            stall,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error,
  output logic            mem_read,
  output logic            mem_write,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RD     = 3'd1;
  localparam logic [2:0] S_WR     = 3'd2;
  localparam logic [2:0] S_RMW_RD = 3'd3;
  localparam logic [2:0] S_RMW_WR = 3'd4;
  localparam logic [2:0] S_RESP   = 3'd5;

  localparam logic [63:0] MEM_BYTES = 64'(MEM_WORDS) << 3;

  logic [2:0]  state;
  logic        wr_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [63:0] addr_q, wdata_q, old_q, rdata_q;

  // ---------------- acceptance-time decode (live request fields) ----------
  logic        accept, range_err, misalign, acc_err;
  logic [63:0] align_mask, acc_addr;

  always_comb begin
    accept    = req_valid && (state == S_IDLE);
    range_err = (req_addr >= MEM_BYTES);
    case (req_size)
      2'd0:    align_mask = 64'd0;
      2'd1:    align_mask = 64'd1;
      2'd2:    align_mask = 64'd3;
      default: align_mask = 64'd7;
    endcase
    misalign = |(req_addr & align_mask);
`ifdef DMEM_MISALIGN_TRAP_EN
    acc_err  = range_err || misalign;
    acc_addr = req_addr;
`else
    acc_err  = range_err;
    acc_addr = req_addr & ~align_mask;
`endif
  end

  // ---------------- load lane extraction ----------------------------------
  logic [2:0]  off;
  logic [63:0] lane, load_ext;

  always_comb begin
    off  = addr_q[2:0];
    lane = mem_rdata >> {off, 3'b000};
    case (size_q)
      2'd0:    load_ext = {{56{~uns_q & lane[7]}},  lane[7:0]};
      2'd1:    load_ext = {{48{~uns_q & lane[15]}}, lane[15:0]};
      2'd2:    load_ext = {{32{~uns_q & lane[31]}}, lane[31:0]};
      default: load_ext = lane;
    endcase
  end

  // ---------------- store merge (RMW) --------------------------------------
  logic [7:0]  size_be, be;
  logic [63:0] wsh, merged;

  always_comb begin
    case (size_q)
      2'd0:    size_be = 8'h01;
      2'd1:    size_be = 8'h03;
      2'd2:    size_be = 8'h0F;
      default: size_be = 8'hFF;
    endcase
    be  = 8'(size_be << off);
    wsh = wdata_q << {off, 3'b000};
  end

  for (genvar i = 0; i < 8; i++) begin : g_lane
    dmem_byte_lane u_lane (
      .sel   (be[i]),
      .old_b (old_q[8*i +: 8]),
      .new_b (wsh[8*i +: 8]),
      .out_b (merged[8*i +: 8])
    );
  end

  // ---------------- state and captured request ----------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 64'd0;
      wdata_q <= 64'd0;
      old_q   <= 64'd0;
      rdata_q <= 64'd0;
    end else begin
      case (state)
        S_IDLE: if (accept) begin
          wr_q    <= req_write;
          uns_q   <= req_unsigned;
          size_q  <= req_size;
          addr_q  <= acc_addr;
          wdata_q <= req_wdata;
          err_q   <= acc_err;
          old_q   <= 64'd0;
          rdata_q <= 64'd0;
          if (acc_err)             state <= S_RESP;
          else if (!req_write)     state <= S_RD;
          else if (req_size == 2'd3) state <= S_WR;
          else                     state <= S_RMW_RD;
        end
        S_RD: begin
          rdata_q <= load_ext;
          state   <= S_RESP;
        end
        S_RMW_RD: begin
          old_q <= mem_rdata;
          state <= S_RMW_WR;
        end
        S_RMW_WR: state <= S_RESP;
        S_WR:     state <= S_RESP;
        default:  state <= S_IDLE;   // S_RESP and any unused encoding
      endcase
    end
  end

  // ---------------- outputs ------------------------------------------------
  always_comb begin
    req_ready  = (state == S_IDLE);
    resp_valid = (state == S_RESP);
    stall      = (req_valid && !resp_valid) || (state != S_IDLE);
    resp_rdata = resp_valid ? rdata_q : 64'd0;
    resp_error = resp_valid && err_q;
    mem_read   = (state == S_RD) || (state == S_RMW_RD);
    mem_write  = (state == S_WR) || (state == S_RMW_WR);
    mem_addr   = (mem_read || mem_write) ? {addr_q[63:3], 3'b000} : 64'd0;
    case (state)
      S_WR:     mem_wdata = wdata_q;
      S_RMW_WR: mem_wdata = merged;
      default:  mem_wdata = 64'd0;
    endcase
  end

  // wr_q is kept for debug visibility of the captured request
  logic unused_ok;
  assign unused_ok = wr_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
module tb_dmem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [63:0] req_addr, req_wdata;
  logic        req_ready, stall, resp_valid, resp_error;
  logic [63:0] resp_rdata;
  logic        mem_read, mem_write;
  logic [63:0] mem_addr, mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  dmem_access_ctrl #(.MEM_WORDS(1024), .XLEN(64)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .stall(stall),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // memory stub
  logic [63:0] mem [0:1023];
  assign mem_rdata = mem[mem_addr[12:3]];
  always @(posedge clk) if (mem_write) mem[mem_addr[12:3]] <= mem_wdata;

  // reference copy of the words the bench touches
  logic [63:0] shadow [0:7];

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // response monitor / scoreboard
  always @(negedge clk) begin
    if (!reset) begin
      if (mem_read || mem_write) begin
        chk("rw_excl", {63'd0, mem_read & mem_write}, 64'd0);
        chk("maddr_align", {61'd0, mem_addr[2:0]}, 64'd0);
      end
      if (resp_valid) begin
        if (sb.size() == 0) chk("sb_unexpected", 64'd1, 64'd0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("rdata", resp_rdata, e.rdata);
          chk("err", {63'd0, resp_error}, {63'd0, e.err});
        end
      end
    end
  end

  function automatic logic [63:0] m_load(input logic [63:0] w, input int off,
                                         input int sz, input logic uns);
    int nb;
    logic [63:0] r;
    nb = 1 << sz;
    r  = 64'd0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = w[8*(off+i) +: 8];
    if (!uns && sz != 3 && r[8*nb-1])
      for (int i = nb; i < 8; i++) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [63:0] m_store(input logic [63:0] w, input int off,
                                          input int sz, input logic [63:0] d);
    logic [63:0] r;
    r = w;
    for (int i = 0; i < (1 << sz); i++) r[8*(off+i) +: 8] = d[8*i +: 8];
    return r;
  endfunction

  int rd_at, wr_at;

  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [63:0] addr, input logic [63:0] wd,
                        input logic [63:0] exp_rd, input logic exp_err,
                        input int exp_lat, input int exp_nrd, input int exp_nwr);
    int lat, nrd, nwr;
    @(negedge clk);
    chk("ready_idle", {63'd0, req_ready}, 64'd1);
    sb.push_back('{rdata: exp_rd, err: exp_err});
    req_valid = 1'b1; req_write = w; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd;
    lat = 0; nrd = 0; nwr = 0; rd_at = 0; wr_at = 0;
    forever begin
      @(posedge clk); #1;
      lat++;
      if (mem_read)  begin nrd++; rd_at = lat; end
      if (mem_write) begin nwr++; wr_at = lat; end
      if (resp_valid) break;
      if (lat > 10) begin chk("timeout", 64'd1, 64'd0); break; end
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("n_read", 64'(nrd), 64'(exp_nrd));
    chk("n_write", 64'(nwr), 64'(exp_nwr));
    chk("ready_resp", {63'd0, req_ready}, 64'd0);
    @(negedge clk); #1;
    req_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 64'd0;
    mem[0] = 64'h0000_0000_0000_0080;
    mem[1] = 64'h1122_3344_5566_7788;
    for (int i = 0; i < 8; i++) shadow[i] = mem[i];

    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; req_addr = 64'd0; req_wdata = 64'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_stall", {63'd0, stall}, 64'd0);
    chk("rst_resp", {63'd0, resp_valid}, 64'd0);
    chk("rst_mem", {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst_maddr", mem_addr, 64'd0);
    @(negedge clk); reset = 1'b0;

    // byte loads, signed then unsigned
    do_req(0, 2'd0, 0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, 0, 2, 1, 0);
    do_req(0, 2'd0, 1, 64'h0, 64'h0, 64'h80, 0, 2, 1, 0);

    // byte store via read-modify-write
    shadow[1] = m_store(shadow[1], 3, 0, 64'hAB);
    do_req(1, 2'd0, 0, 64'hB, 64'hFFFF_FFFF_FFFF_FFAB, 64'h0, 0, 3, 1, 1);
    chk("rmw_rd_at", 64'(rd_at), 64'd1);
    chk("rmw_wr_at", 64'(wr_at), 64'd2);
    chk("word1", mem[1], 64'h1122_3344_AB66_7788);

    // double store then load back
    shadow[2] = 64'hDEAD_BEEF_0000_0001;
    do_req(1, 2'd3, 0, 64'h10, 64'hDEAD_BEEF_0000_0001, 64'h0, 0, 2, 0, 1);
    chk("word2", mem[2], 64'hDEAD_BEEF_0000_0001);
    do_req(0, 2'd3, 1, 64'h10, 64'h0, 64'hDEAD_BEEF_0000_0001, 0, 2, 1, 0);

    // out of range
    do_req(0, 2'd2, 0, 64'h2000, 64'h0, 64'h0, 1, 1, 0, 0);
    // last valid word is fine
    do_req(0, 2'd3, 0, 64'h1FF8, 64'h0, 64'h0, 0, 2, 1, 0);

    // misaligned halves
`ifdef DMEM_MISALIGN_TRAP_EN
    do_req(0, 2'd1, 0, 64'h3, 64'h0, 64'h0, 1, 1, 0, 0);
    do_req(0, 2'd1, 0, 64'h9, 64'h0, 64'h0, 1, 1, 0, 0);
`else
    do_req(0, 2'd1, 0, 64'h3, 64'h0, m_load(shadow[0], 2, 1, 0), 0, 2, 1, 0);
    do_req(0, 2'd1, 0, 64'h9, 64'h0, m_load(shadow[1], 0, 1, 0), 0, 2, 1, 0);
`endif

    // random aligned traffic over words 2..5
    for (int k = 0; k < 16; k++) begin
      int sz, wi, off;
      logic w, uns;
      logic [63:0] d;
      sz  = $urandom_range(0, 3);
      wi  = $urandom_range(2, 5);
      off = $urandom_range(0, 7) & ~((1 << sz) - 1);
      w   = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      d   = {$urandom, $urandom};
      if (w) begin
        shadow[wi] = m_store(shadow[wi], off, sz, d);
        do_req(1, 2'(sz), uns, 64'(wi*8 + off), d, 64'h0, 0,
               (sz == 3) ? 2 : 3, (sz == 3) ? 0 : 1, 1);
        chk("rand_word", mem[wi], shadow[wi]);
      end else begin
        do_req(0, 2'(sz), uns, 64'(wi*8 + off), 64'h0,
               m_load(shadow[wi], off, sz, uns), 0, 2, 1, 0);
      end
    end

    // reset during RMW_RD of a byte store: no write may occur
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 64'hC; req_wdata = 64'h5A;
    @(posedge clk); #1;
    chk("rmw_rd_state", {63'd0, mem_read}, 64'd1);
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_mid_mem", {62'd0, mem_read, mem_write}, 64'd0);
    chk("rst_mid_resp", {63'd0, resp_valid}, 64'd0);
    @(posedge clk); #1;
    chk("rst_mid_word", mem[1], shadow[1]);
    @(negedge clk); reset = 1'b0;

    // controller still works after the interrupted store
    do_req(0, 2'd2, 1, 64'h8, 64'h0, m_load(shadow[1], 0, 2, 1), 0, 2, 1, 0);

    repeat (2) @(posedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
